// File: rtl/regfile_pkg.sv
// Shared constants and requester encoding for the register-file port scheduler.
package regfile_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned IDXW = $clog2(NREG);

  // Encoding doubles as the bit position in request/grant vectors.
  typedef enum logic [1:0] {SRC_READ, SRC_ALU, SRC_LD} src_e;
endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter. The search starts after the most recent grant.
module rr_arb3
  import regfile_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o
);
  src_e last_q, last_d;
  src_e o0, o1, o2, sel;
  logic hit;

  always_comb begin
    o0 = SRC_READ;
    o1 = SRC_ALU;
    o2 = SRC_LD;
    case (last_q)
      SRC_READ: begin o0 = SRC_ALU; o1 = SRC_LD;   o2 = SRC_READ; end
      SRC_ALU:  begin o0 = SRC_LD;  o1 = SRC_READ; o2 = SRC_ALU;  end
      default:  begin o0 = SRC_READ; o1 = SRC_ALU; o2 = SRC_LD;   end
    endcase
  end

  always_comb begin
    sel    = SRC_READ;
    hit    = 1'b1;
    gnt_o  = '0;
    last_d = last_q;
    if (req_i[o0])      sel = o0;
    else if (req_i[o1]) sel = o1;
    else if (req_i[o2]) sel = o2;
    else                hit = 1'b0;
    // Nothing is granted while reset is held, so no partial write escapes.
    if (hit && reset) begin
      gnt_o[sel] = 1'b1;
      last_d     = sel;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) last_q <= SRC_LD;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/regfile_sched.sv
// Single-port register-file scheduler: arbitrates one reader and two writers,
// and holds a scoreboard of registers with loads still in flight.
module regfile_sched
  import regfile_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            rd_req,
  input  logic [IDXW-1:0] rd_rs1,
  input  logic [IDXW-1:0] rd_rs2,
  output logic            rd_gnt,
  input  logic            alu_wvalid,
  input  logic [IDXW-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_wdata,
  output logic            alu_wready,
  input  logic            ld_wvalid,
  input  logic [IDXW-1:0] ld_rd,
  input  logic [XLEN-1:0] ld_wdata,
  output logic            ld_wready,
  input  logic            ld_issue,
  input  logic [IDXW-1:0] ld_issue_rd,
  output logic [NREG-1:0] busy,
  output logic            rf_write,
  output logic [IDXW-1:0] rf_rs1,
  output logic [IDXW-1:0] rf_rs2,
  output logic [IDXW-1:0] rf_rd,
  output logic [XLEN-1:0] rf_writedata
);
  logic [NREG-1:0] busy_q, busy_d;
  logic [2:0]      req, gnt;
  logic [IDXW-1:0] wr_tgt;
  logic [XLEN-1:0] wr_data;

  // Reads and ALU writes wait behind pending loads; load writes never do.
  assign req[SRC_READ] = rd_req && !busy_q[rd_rs1] && !busy_q[rd_rs2];
  assign req[SRC_ALU]  = alu_wvalid && !busy_q[alu_rd];
  assign req[SRC_LD]   = ld_wvalid;

  rr_arb3 u_arb (
    .clock (clock),
    .reset (reset),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign rd_gnt     = gnt[SRC_READ];
  assign alu_wready = gnt[SRC_ALU];
  assign ld_wready  = gnt[SRC_LD];
  assign wr_tgt     = gnt[SRC_LD] ? ld_rd : alu_rd;
  assign wr_data    = gnt[SRC_LD] ? ld_wdata : alu_wdata;

  always_comb begin
    rf_write     = 1'b0;
    rf_rs1       = '0;
    rf_rs2       = '0;
    rf_rd        = '0;
    rf_writedata = '0;
    if (rd_gnt) begin
      rf_rs1 = rd_rs1;
      rf_rs2 = rd_rs2;
    end else if (alu_wready || ld_wready) begin
      // The file decodes writes through rs1/rs2, so all three carry the target.
      rf_rs1       = wr_tgt;
      rf_rs2       = wr_tgt;
      rf_rd        = wr_tgt;
      rf_writedata = wr_data;
      rf_write     = (wr_tgt != '0);
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (ld_wready) busy_d[ld_rd] = 1'b0;
    // Applied after the clear so a same-index issue wins.
    if (ld_issue && ld_issue_rd != '0) busy_d[ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule
